// File: rtl/clock_pkg.sv
//------------------------------------------------------------------------------
// Module      : clock_pkg
// Description : Shared BCD types, constants and helpers for the time-of-day core.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_field_t;

  typedef struct packed {
    bcd_field_t hh;
    bcd_field_t mm;
    bcd_field_t ss;
  } time_t;

  localparam bcd_field_t BCD_59 = 8'h59;
  localparam bcd_field_t BCD_23 = 8'h23;
  localparam bcd_field_t BCD_12 = 8'h12;

  // Valid BCD orders the same as binary, so a plain compare checks the range.
  function automatic logic bcd_valid(input bcd_field_t field, input bcd_field_t max);
    return (field[7:4] <= 4'd9) && (field[3:0] <= 4'd9) && (field <= max);
  endfunction

  function automatic bcd_field_t to_12h(input bcd_field_t hh);
    logic [4:0] bin;
    logic [4:0] b12;
    bin = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
    b12 = bin - 5'd12;
    if (bin == 5'd0)
      return BCD_12;
    else if (bin > 5'd12)
      return (b12 >= 5'd10) ? {4'd1, 4'(b12 - 5'd10)} : {4'd0, 4'(b12)};
    else
      return hh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_field_counter.sv
//------------------------------------------------------------------------------
// Module      : bcd_field_counter
// Description : Two-digit BCD counter wrapping at MAX_BCD, with validated preload.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_field_counter
  import clock_pkg::*;
#(
  parameter bcd_field_t MAX_BCD = BCD_59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  bcd_field_t load_val,
  output bcd_field_t value,
  output logic       at_max
);

  bcd_field_t value_q;
  bcd_field_t value_d;

  assign value  = value_q;
  assign at_max = (value_q == MAX_BCD);

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = bcd_valid(load_val, MAX_BCD) ? load_val : 8'h00;
    end else if (inc) begin
      if (at_max)
        value_d = 8'h00;
      else if (value_q[3:0] == 4'd9)
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      else
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      value_q <= 8'h00;
    else
      value_q <= value_d;
  end

endmodule

`default_nettype wire

// File: rtl/bcd_clock_core.sv
//------------------------------------------------------------------------------
// Module      : bcd_clock_core
// Description : BCD HH:MM:SS time-of-day core with set buttons, preload,
//               12/24h display, seconds strobe and hourly chime pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_clock_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int SET_HZ = 5,
  parameter int DIV_W  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  set_n,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        mode_12h,
  output logic [23:0] time_out,
  output logic        pm,
  output logic        sec_tick,
  output logic        hour_flag
);

  localparam int               SDIV_W    = (SET_HZ > 1) ? $clog2(SET_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_HZ / SET_HZ - 1);
  localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(SET_HZ - 1);

  logic [DIV_W-1:0]  presc_q;
  logic [SDIV_W-1:0] sdiv_q;
  logic              set_tick;
  logic              adv_sec;
  logic              inc_ss, inc_mm, inc_hh;
  logic              ss_max, mm_max, hh_max;
  logic              sec_pend_q, hour_pend_q;
  time_t             now;
  time_t             load_t;
  logic [23:0]       time_out_q;
  logic              pm_q, sec_tick_q, hour_flag_q;

  assign load_t   = time_t'(load_time);
  assign set_tick = en && (presc_q == DIV_LAST);
  assign adv_sec  = set_tick && (sdiv_q == SDIV_LAST);

  // Natural carries look only at adv_sec, so a button-driven wrap never ripples up.
  assign inc_ss = adv_sec || (set_tick && !set_n[0]);
  assign inc_mm = (adv_sec && ss_max) || (set_tick && !set_n[1]);
  assign inc_hh = (adv_sec && ss_max && mm_max) || (set_tick && !set_n[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      sdiv_q  <= '0;
    end else if (load) begin
      presc_q <= '0;
      sdiv_q  <= '0;
    end else if (en) begin
      presc_q <= set_tick ? '0 : presc_q + 1'b1;
      if (set_tick)
        sdiv_q <= (sdiv_q == SDIV_LAST) ? '0 : sdiv_q + 1'b1;
    end
  end

  bcd_field_counter #(.MAX_BCD(BCD_59)) u_ss (
    .clk(clk), .rst(rst), .inc(inc_ss), .load(load),
    .load_val(load_t.ss), .value(now.ss), .at_max(ss_max)
  );

  bcd_field_counter #(.MAX_BCD(BCD_59)) u_mm (
    .clk(clk), .rst(rst), .inc(inc_mm), .load(load),
    .load_val(load_t.mm), .value(now.mm), .at_max(mm_max)
  );

  bcd_field_counter #(.MAX_BCD(BCD_23)) u_hh (
    .clk(clk), .rst(rst), .inc(inc_hh), .load(load),
    .load_val(load_t.hh), .value(now.hh), .at_max(hh_max)
  );

  // Strobes are staged twice so they line up with the display register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_pend_q  <= 1'b0;
      hour_pend_q <= 1'b0;
      time_out_q  <= 24'h0;
      pm_q        <= 1'b0;
      sec_tick_q  <= 1'b0;
      hour_flag_q <= 1'b0;
      if (mode_12h)
        time_out_q <= {BCD_12, 16'h0000};
    end else begin
      sec_pend_q  <= adv_sec && !load;
      hour_pend_q <= adv_sec && ss_max && mm_max && !load;
      time_out_q  <= {(mode_12h ? to_12h(now.hh) : now.hh), now.mm, now.ss};
      pm_q        <= (now.hh >= BCD_12);
      sec_tick_q  <= sec_pend_q;
      hour_flag_q <= hour_pend_q;
    end
  end

  assign time_out  = time_out_q;
  assign pm        = pm_q;
  assign sec_tick  = sec_tick_q;
  assign hour_flag = hour_flag_q;

  logic unused_ok;
  assign unused_ok = hh_max;

endmodule

`default_nettype wire

// File: tb/tb_bcd_clock_core.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd_clock_core
// Description : Self-checking bench for bcd_clock_core against a seconds/minutes/
//               hours integer model of the clock.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_clock_core;

  localparam int CLK_HZ = 50;
  localparam int SET_HZ = 5;
  localparam int DIV_N  = CLK_HZ / SET_HZ;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  set_n = 3'b111;
  logic        load = 1'b0;
  logic [23:0] load_time = 24'h0;
  logic        mode_12h = 1'b0;
  logic [23:0] time_out;
  logic        pm, sec_tick, hour_flag;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: plain integers for the clock, prescaler and divider.
  int  mh = 0, mmn = 0, ms = 0, mp = 0, md = 0;
  bit  m_sec_pend = 0, m_hour_pend = 0;
  logic [23:0] e_time = 24'h0;
  logic        e_pm = 0, e_sec = 0, e_hour = 0;

  bcd_clock_core #(.CLK_HZ(CLK_HZ), .SET_HZ(SET_HZ), .DIV_W(24)) dut (
    .clk(clk), .rst(rst), .en(en), .set_n(set_n), .load(load),
    .load_time(load_time), .mode_12h(mode_12h), .time_out(time_out),
    .pm(pm), .sec_tick(sec_tick), .hour_flag(hour_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int dec_field(input logic [7:0] f, input int max);
    int v;
    if (f[7:4] > 4'd9 || f[3:0] > 4'd9) return 0;
    v = int'(f[7:4]) * 10 + int'(f[3:0]);
    return (v > max) ? 0 : v;
  endfunction

  function automatic int hour12(input int h);
    if (h == 0) return 12;
    return (h > 12) ? h - 12 : h;
  endfunction

  task automatic model_edge();
    bit st, adv, i_s, i_m, i_h;
    if (rst) begin
      e_time = mode_12h ? 24'h120000 : 24'h0;
      e_pm = 0; e_sec = 0; e_hour = 0;
      mh = 0; mmn = 0; ms = 0; mp = 0; md = 0;
      m_sec_pend = 0; m_hour_pend = 0;
    end else begin
      e_time = {bcd(mode_12h ? hour12(mh) : mh), bcd(mmn), bcd(ms)};
      e_pm   = (mh >= 12);
      e_sec  = m_sec_pend;
      e_hour = m_hour_pend;
      m_sec_pend = 0; m_hour_pend = 0;
      if (load) begin
        mh  = dec_field(load_time[23:16], 23);
        mmn = dec_field(load_time[15:8], 59);
        ms  = dec_field(load_time[7:0], 59);
        mp = 0; md = 0;
      end else if (en) begin
        st  = (mp == DIV_N - 1);
        adv = st && (md == SET_HZ - 1);
        i_s = adv || (st && !set_n[0]);
        i_m = (adv && ms == 59) || (st && !set_n[1]);
        i_h = (adv && ms == 59 && mmn == 59) || (st && !set_n[2]);
        m_sec_pend  = adv;
        m_hour_pend = adv && ms == 59 && mmn == 59;
        ms  = (ms + int'(i_s)) % 60;
        mmn = (mmn + int'(i_m)) % 60;
        mh  = (mh + int'(i_h)) % 24;
        mp  = st ? 0 : mp + 1;
        if (st) md = (md + 1) % SET_HZ;
      end
    end
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("time_out", time_out, e_time);
    check("pm", {23'd0, pm}, {23'd0, e_pm});
    check("sec_tick", {23'd0, sec_tick}, {23'd0, e_sec});
    check("hour_flag", {23'd0, hour_flag}, {23'd0, e_hour});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [23:0] v);
    load = 1'b1; load_time = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    // Reset and free-running count.
    rst = 1'b1; cyc(); rst = 1'b0;
    check("reset_time", time_out, 24'h000000);
    en = 1'b1;
    run(51);
    check("count_1s", time_out, 24'h000001);
    check("count_tick", {23'd0, sec_tick}, 24'd1);
    run(1);
    check("tick_width", {23'd0, sec_tick}, 24'd0);
    run(99);
    check("count_3s", time_out, 24'h000003);

    // Full carry across midnight.
    do_load(24'h235959);
    run(1);
    check("carry_pre", time_out, 24'h235959);
    check("carry_pm_pre", {23'd0, pm}, 24'd1);
    run(50);
    check("carry_post", time_out, 24'h000000);
    check("carry_hour", {23'd0, hour_flag}, 24'd1);
    check("carry_pm_post", {23'd0, pm}, 24'd0);
    run(1);
    check("hour_width", {23'd0, hour_flag}, 24'd0);

    // Minute set button wraps without carrying into hours.
    set_n = 3'b101;
    do_load(24'h105930);
    run(31);
    check("set_min", time_out, 24'h100230);
    en = 1'b0;
    run(30);
    check("set_frozen", time_out, 24'h100230);
    en = 1'b1; set_n = 3'b111;

    // Seconds button held across a natural advance: single increment.
    set_n = 3'b110;
    do_load(24'h000058);
    run(51);
    check("coincide", time_out, 24'h000003);
    set_n = 3'b111;

    // Load validation and priority.
    do_load({8'h2A, 8'h61, 8'h45});
    run(1);
    check("load_valid", time_out, 24'h000045);
    rst = 1'b1; load = 1'b1; load_time = 24'h123456;
    cyc();
    rst = 1'b0; load = 1'b0;
    check("rst_over_load", time_out, 24'h000000);
    en = 1'b0;
    do_load(24'h123456);
    run(1);
    check("load_en0", time_out, 24'h123456);

    // 12-hour display.
    mode_12h = 1'b1;
    do_load(24'h001500); run(1);
    check("h12_midnight", time_out, 24'h121500);
    check("h12_am", {23'd0, pm}, 24'd0);
    do_load(24'h120000); run(1);
    check("h12_noon", time_out, 24'h120000);
    check("h12_noon_pm", {23'd0, pm}, 24'd1);
    do_load(24'h235959); run(1);
    check("h12_late", time_out, 24'h115959);
    mode_12h = 1'b0;
    run(1);
    check("mode_toggle", time_out, 24'h235959);
    en = 1'b1;

    // Randomized phase against the model.
    for (int i = 0; i < 6000; i++) begin
      en       = ($urandom_range(0, 19) != 0);
      set_n    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
      mode_12h = ($urandom_range(0, 99) == 0) ? ~mode_12h : mode_12h;
      rst      = ($urandom_range(0, 999) == 0);
      load     = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0)
        load_time = 24'($urandom);
      else
        load_time = {bcd($urandom_range(0, 23)), 8'h59, bcd($urandom_range(50, 59))};
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
